// File: rtl/ps2_dev_tx.sv
// ---------------------------------------------------------------------------
// ps2_dev_tx
//   Device-side PS/2 transmitter. Scan-code bytes are accepted on a
//   valid/ready interface and queued in a small FIFO. Each byte is sent as
//   an 11-bit frame (start 0, data LSB first, odd parity, stop 1) on
//   generated clock/data lines. A host inhibit before the stop bit aborts
//   the frame; the byte is kept and sent again once the inhibit clears.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   din           byte to send
//   din_valid     din is presented
//   din_ready     FIFO can accept (transfer on din_valid & din_ready)
//   inhibit       host inhibit, already synchronised to clk
//   ps2_kbd_clk   PS/2 clock, idle high
//   ps2_kbd_data  PS/2 data, idle high
//   busy          frame/gap in progress or FIFO non-empty
//   abort_cnt     saturating count of frames aborted by inhibit
// ---------------------------------------------------------------------------
module ps2_dev_tx #(
    parameter int CLK_DIV    = 600,
    parameter int IDLE_GAP   = 1200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic       inhibit,
    output logic       ps2_kbd_clk,
    output logic       ps2_kbd_data,
    output logic       busy,
    output logic [7:0] abort_cnt
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int TMR_MAX = (CLK_DIV > IDLE_GAP) ? CLK_DIV : IDLE_GAP;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] SLOT_LOAD      = TMR_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD       = TMR_W'(IDLE_GAP - 1);
    localparam logic [TMR_W-1:0] TMR_ZERO       = TMR_W'(0);
    localparam logic [TMR_W-1:0] TMR_ONE        = TMR_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL       = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO       = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE        = PTR_W'(1);
    localparam logic [3:0]       LAST_BIT       = 4'd10;
    localparam logic [3:0]       LAST_ABORTABLE = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SLOT_HI = 3'd2,
        ST_SLOT_LO = 3'd3,
        ST_GAP     = 3'd4,
        ST_HOLD    = 3'd5
    } state_t;

    // Odd parity bit: set when the byte holds an even number of ones.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    // Full frame, bit 0 transmitted first.
    function automatic logic [10:0] build_frame(input logic [7:0] b);
        return {1'b1, odd_parity(b), b, 1'b0};
    endfunction

    // ---------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ---------------------------------------------------------------------
    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_s;
    logic             push_s;
    logic             pop_s;
    logic             fifo_empty_s;
    logic [7:0]       fifo_head_s;

    assign din_ready    = (count_r != CNT_FULL);
    assign push_s       = din_valid & din_ready;
    assign fifo_empty_s = (count_r == CNT_ZERO);
    assign fifo_head_s  = mem_r[rd_ptr_r];

    // Next FIFO occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CNT_ONE;
            2'b01:   count_s = count_r - CNT_ONE;
            default: count_s = count_r;
        endcase
    end

    // FIFO storage, pointers (wrap naturally at the power-of-2 depth) and count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_s;
        end
    end

    // ---------------------------------------------------------------------
    // Frame sequencer
    // ---------------------------------------------------------------------
    state_t           state_r, state_s;
    logic [TMR_W-1:0] timer_r, timer_s;
    logic [3:0]       bit_idx_r, bit_idx_s;
    logic [10:0]      frame_r, frame_s;
    logic [7:0]       byte_r, byte_s;
    logic             clk_out_r, clk_out_s;
    logic             data_out_r, data_out_s;
    logic             abort_s;
    logic             busy_r, busy_s;
    logic [7:0]       abort_cnt_r;
    logic             can_abort_s;

    assign can_abort_s = inhibit && (bit_idx_r <= LAST_ABORTABLE);

    // Next-state, next line levels and FIFO pop request.
    always_comb begin
        state_s    = state_r;
        timer_s    = timer_r;
        bit_idx_s  = bit_idx_r;
        frame_s    = frame_r;
        byte_s     = byte_r;
        clk_out_s  = clk_out_r;
        data_out_s = data_out_r;
        pop_s      = 1'b0;
        abort_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                clk_out_s  = 1'b1;
                data_out_s = 1'b1;
                if (!fifo_empty_s && !inhibit) begin
                    pop_s   = 1'b1;
                    byte_s  = fifo_head_s;
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_LOAD: begin
                frame_s    = build_frame(byte_r);
                bit_idx_s  = 4'd0;
                timer_s    = SLOT_LOAD;
                clk_out_s  = 1'b1;
                data_out_s = 1'b0;
                state_s    = ST_SLOT_HI;
            end

            ST_SLOT_HI: begin
                if (can_abort_s) begin
                    clk_out_s  = 1'b1;
                    data_out_s = 1'b1;
                    abort_s    = 1'b1;
                    timer_s    = GAP_LOAD;
                    state_s    = ST_HOLD;
                end else if (timer_r == TMR_ZERO) begin
                    clk_out_s = 1'b0;
                    timer_s   = SLOT_LOAD;
                    state_s   = ST_SLOT_LO;
                end else begin
                    timer_s = timer_r - TMR_ONE;
                end
            end

            ST_SLOT_LO: begin
                if (can_abort_s) begin
                    clk_out_s  = 1'b1;
                    data_out_s = 1'b1;
                    abort_s    = 1'b1;
                    timer_s    = GAP_LOAD;
                    state_s    = ST_HOLD;
                end else if (timer_r == TMR_ZERO) begin
                    clk_out_s = 1'b1;
                    if (bit_idx_r < LAST_BIT) begin
                        // Data only moves on entry to the high phase.
                        bit_idx_s  = bit_idx_r + 4'd1;
                        data_out_s = frame_r[bit_idx_r + 4'd1];
                        timer_s    = SLOT_LOAD;
                        state_s    = ST_SLOT_HI;
                    end else begin
                        data_out_s = 1'b1;
                        timer_s    = GAP_LOAD;
                        state_s    = ST_GAP;
                    end
                end else begin
                    timer_s = timer_r - TMR_ONE;
                end
            end

            ST_GAP: begin
                clk_out_s  = 1'b1;
                data_out_s = 1'b1;
                if (timer_r == TMR_ZERO) begin
                    if (!fifo_empty_s && !inhibit) begin
                        // Queued byte: start the next frame straight away so
                        // the quiet time between frames is exactly IDLE_GAP.
                        pop_s      = 1'b1;
                        byte_s     = fifo_head_s;
                        frame_s    = build_frame(fifo_head_s);
                        bit_idx_s  = 4'd0;
                        timer_s    = SLOT_LOAD;
                        data_out_s = 1'b0;
                        state_s    = ST_SLOT_HI;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    timer_s = timer_r - TMR_ONE;
                end
            end

            ST_HOLD: begin
                // Retained byte goes out again ahead of anything in the FIFO.
                clk_out_s  = 1'b1;
                data_out_s = 1'b1;
                if (inhibit) begin
                    timer_s = GAP_LOAD;
                end else if (timer_r == TMR_ZERO) begin
                    state_s = ST_LOAD;
                end else begin
                    timer_s = timer_r - TMR_ONE;
                end
            end

            default: begin
                clk_out_s  = 1'b1;
                data_out_s = 1'b1;
                state_s    = ST_IDLE;
            end
        endcase
    end

    assign busy_s = (state_s != ST_IDLE) || (count_s != CNT_ZERO);

    // Sequencer registers and registered line/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            timer_r    <= TMR_ZERO;
            bit_idx_r  <= 4'd0;
            frame_r    <= 11'h7FF;
            byte_r     <= 8'h00;
            clk_out_r  <= 1'b1;
            data_out_r <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            timer_r    <= timer_s;
            bit_idx_r  <= bit_idx_s;
            frame_r    <= frame_s;
            byte_r     <= byte_s;
            clk_out_r  <= clk_out_s;
            data_out_r <= data_out_s;
            busy_r     <= busy_s;
        end
    end

    // Saturating abort counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            abort_cnt_r <= 8'h00;
        end else if (abort_s && (abort_cnt_r != 8'hFF)) begin
            abort_cnt_r <= abort_cnt_r + 8'h01;
        end else begin
            abort_cnt_r <= abort_cnt_r;
        end
    end

    assign ps2_kbd_clk  = clk_out_r;
    assign ps2_kbd_data = data_out_r;
    assign busy         = busy_r;
    assign abort_cnt    = abort_cnt_r;

endmodule

// File: tb/tb_ps2_dev_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_dev_tx
//   Scoreboard bench for ps2_dev_tx. Accepted bytes are queued as expected
//   frames; a line monitor decodes frames at the falling PS/2 clock edges and
//   compares them (byte, start, parity, stop) against the queue.
// ---------------------------------------------------------------------------
module tb_ps2_dev_tx;

    localparam int CD  = 4;
    localparam int GAP = 8;
    localparam int DEP = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       inhibit;
    logic       ps2_kbd_clk;
    logic       ps2_kbd_data;
    logic       busy;
    logic [7:0] abort_cnt;

    ps2_dev_tx #(.CLK_DIV(CD), .IDLE_GAP(GAP), .FIFO_DEPTH(DEP)) dut (
        .clk          (clk),
        .reset        (reset),
        .din          (din),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .inhibit      (inhibit),
        .ps2_kbd_clk  (ps2_kbd_clk),
        .ps2_kbd_data (ps2_kbd_data),
        .busy         (busy),
        .abort_cnt    (abort_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // cycle counter, updated on the edge so every #1/#2 reader sees one value
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: bytes accepted by the DUT, in order
    logic [7:0] sb[$];
    always @(posedge clk) begin
        if (!reset && din_valid && din_ready) sb.push_back(din);
    end

    // line monitor state
    int          nbits = 0;
    int          nfalls = 0;
    int          frames = 0;
    int          high_run = 0;
    int          low_run = 0;
    int          end_cyc = 0;
    int          data_fall_cyc = 0;
    logic        prev_clk = 1'b1;
    logic        prev_data = 1'b1;
    logic [10:0] bits_v = '0;
    logic        last_par = 1'b0;
    logic        skip_len = 1'b0;
    logic        check_gap = 1'b0;

    always @(posedge clk) begin
        #1;
        if (reset) begin
            nbits     = 0;
            high_run  = 0;
            low_run   = 0;
            prev_clk  = 1'b1;
            prev_data = 1'b1;
        end else begin
            if (prev_clk && !ps2_kbd_clk) begin
                if (nbits < 11) bits_v[nbits] = ps2_kbd_data;
                nbits++;
                nfalls++;
                low_run = 1;
            end else if (!ps2_kbd_clk) begin
                low_run++;
            end else if (!prev_clk) begin
                if (!skip_len) check_val("low_len", low_run, CD);
                high_run = 1;
                if (nbits == 11) begin
                    logic [7:0] exp_b;
                    if (sb.size() == 0) begin
                        check_val("unexpected_frame", bits_v[8:1], 32'hFFFF_FFFF);
                    end else begin
                        exp_b = sb.pop_front();
                        check_val("frame_byte", bits_v[8:1], exp_b);
                        check_val("parity", bits_v[9], ~^exp_b);
                        check_val("start_bit", bits_v[0], 0);
                        check_val("stop_bit", bits_v[10], 1);
                    end
                    last_par = bits_v[9];
                    frames++;
                    end_cyc = cyc;
                    nbits = 0;
                end
            end else begin
                high_run++;
                // clock parked high longer than a slot: partial frame dropped
                if (high_run > CD && nbits != 0) nbits = 0;
                if (prev_data && !ps2_kbd_data && nbits == 0) begin
                    data_fall_cyc = cyc;
                    if (check_gap) check_val("frame_gap", cyc - end_cyc, GAP);
                end
            end
            prev_clk  = ps2_kbd_clk;
            prev_data = ps2_kbd_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int acc_cyc = 0;

    task automatic push_byte(input logic [7:0] b);
        logic r;
        logic done;
        done = 1'b0;
        din = b;
        din_valid = 1'b1;
        for (int i = 0; i < 2000 && !done; i++) begin
            r = din_ready;
            tick();
            if (r) begin
                acc_cyc = cyc;
                done = 1'b1;
            end
        end
        if (!done) check_val("push_timeout", 0, 1);
        din_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        for (int i = 0; i < 3000 && frames < n; i++) tick();
        if (frames < n) check_val("frame_timeout", frames, n);
    endtask

    task automatic wait_bits(input int n, input logic clk_lvl);
        int i;
        for (i = 0; i < 2000 && !(nbits == n && ps2_kbd_clk == clk_lvl); i++) tick();
        if (i >= 2000) check_val("bit_timeout", nbits, n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, rel, nf, bc;
        reset = 1'b1;
        din = 8'h00;
        din_valid = 1'b0;
        inhibit = 1'b0;
        #1;
        check_val("rst_clk", ps2_kbd_clk, 1);
        check_val("rst_data", ps2_kbd_data, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_abort", abort_cnt, 0);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_val("rst_ready", din_ready, 1);

        // basic frame, 0x1C: start bit 2 cycles after accept, busy drops GAP after end
        push_byte(8'h1C);
        wait_frames(1);
        check_val("start_latency", data_fall_cyc - acc_cyc, 2);
        check_val("par_1C", last_par, 0);
        for (bc = 0; bc < 100 && busy; bc++) tick();
        check_val("busy_drop", cyc - end_cyc, GAP);

        // parity cases, queued back to back
        f0 = frames;
        push_byte(8'hF0);
        push_byte(8'h00);
        push_byte(8'hFF);
        wait_frames(f0 + 1);
        check_val("par_F0", last_par, 1);
        check_gap = 1'b1;
        wait_frames(f0 + 2);
        check_val("par_00", last_par, 1);
        wait_frames(f0 + 3);
        check_val("par_FF", last_par, 1);
        check_gap = 1'b0;
        for (bc = 0; bc < 100 && busy; bc++) tick();

        // inhibit in IDLE while filling the FIFO, then back-to-back drain
        inhibit = 1'b1;
        tick();
        f0 = frames;
        push_byte(8'hE0);
        push_byte(8'hF0);
        push_byte(8'h1C);
        push_byte(8'h12);
        check_val("full_ready", din_ready, 0);
        nf = nfalls;
        din = 8'h59;
        din_valid = 1'b1;
        repeat (20) tick();
        check_val("inh_no_clk", nfalls - nf, 0);
        check_val("inh_busy", busy, 1);
        check_val("still_full", din_ready, 0);
        inhibit = 1'b0;
        rel = cyc;
        push_byte(8'h59);
        check_val("accept_59", acc_cyc - rel, 2);
        check_val("release_start", data_fall_cyc - rel, 2);
        wait_frames(f0 + 1);
        check_gap = 1'b1;
        wait_frames(f0 + 5);
        check_gap = 1'b0;
        for (bc = 0; bc < 100 && busy; bc++) tick();

        // inhibit abort during SLOT_LO of bit index 5, then resend
        f0 = frames;
        push_byte(8'h1C);
        push_byte(8'h5A);
        wait_bits(6, 1'b0);
        skip_len = 1'b1;
        inhibit = 1'b1;
        tick();
        skip_len = 1'b0;
        check_val("abort_clk", ps2_kbd_clk, 1);
        check_val("abort_data", ps2_kbd_data, 1);
        check_val("abort_cnt1", abort_cnt, 1);
        nf = nfalls;
        repeat (49) tick();
        check_val("hold_no_clk", nfalls - nf, 0);
        check_val("hold_busy", busy, 1);
        inhibit = 1'b0;
        rel = cyc;
        // one edge to see the release, GAP quiet cycles, then LOAD
        for (bc = 0; bc < 100 && data_fall_cyc <= rel; bc++) tick();
        check_val("resend_start", data_fall_cyc - rel, GAP + 1);
        wait_frames(f0 + 2);
        check_val("abort_cnt_keep", abort_cnt, 1);
        for (bc = 0; bc < 100 && busy; bc++) tick();

        // late inhibit in the stop slot: frame completes, no abort
        f0 = frames;
        push_byte(8'h33);
        wait_bits(10, 1'b1);
        inhibit = 1'b1;
        wait_frames(f0 + 1);
        repeat (3) tick();
        inhibit = 1'b0;
        check_val("late_inh_abort", abort_cnt, 1);
        for (bc = 0; bc < 100 && busy; bc++) tick();

        // reset mid-frame with bytes queued
        push_byte(8'hA1);
        push_byte(8'hB2);
        push_byte(8'hC3);
        wait_bits(4, 1'b0);
        reset = 1'b1;
        #1;
        check_val("arst_clk", ps2_kbd_clk, 1);
        check_val("arst_data", ps2_kbd_data, 1);
        check_val("arst_busy", busy, 0);
        repeat (2) tick();
        reset = 1'b0;
        sb.delete();
        f0 = frames;
        nf = nfalls;
        tick();
        check_val("post_rst_ready", din_ready, 1);
        repeat (300) tick();
        check_val("post_rst_frames", frames - f0, 0);
        check_val("post_rst_falls", nfalls - nf, 0);
        check_val("post_rst_busy", busy, 0);
        check_val("post_rst_abort", abort_cnt, 0);
        check_val("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
